spi_sram_prefetch: RTL and testbench

SPI_SRAM_PREFETCH -- requirements
Module: spi_sram_prefetch

---
 rtl/spi_sram_pkg.sv | 22 ++
 rtl/spi_sram_pfbuf.sv | 44 ++++
 rtl/spi_sram_prefetch.sv | 172 +++++++++++++++++
 tb/tb_spi_sram_prefetch.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sram_pkg.sv
// Shared definitions for the SPI SRAM blocks: bus widths, controller state
// encoding and the wrapping address increment.
package spi_sram_pkg;

    localparam int unsigned AddrW = 24;
    localparam int unsigned DataW = 8;

    // Controller states, kept as plain constants so older blocks can reuse them.
    typedef logic [2:0] state_t;
    localparam state_t StIdle    = 3'd0;
    localparam state_t StRdIssue = 3'd1;
    localparam state_t StRdData  = 3'd2;
    localparam state_t StPfIssue = 3'd3;
    localparam state_t StPfData  = 3'd4;
    localparam state_t StWrIssue = 3'd5;

    // Next byte address; wraps from the top of the 24-bit space back to zero.
    function automatic logic [AddrW-1:0] addr_next(input logic [AddrW-1:0] a);
        return a + 24'd1;
    endfunction

endpackage

// File: rtl/spi_sram_pfbuf.sv
// One-entry prefetch buffer: filled after a read miss, kept coherent by
// write-through updates, invalidated on a new miss, compared against the CPU address.
module spi_sram_pfbuf
    import spi_sram_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inv,
    input  logic             fill,
    input  logic [AddrW-1:0] fill_addr,
    input  logic [DataW-1:0] fill_data,
    input  logic             upd,
    input  logic [AddrW-1:0] upd_addr,
    input  logic [DataW-1:0] upd_data,
    input  logic [AddrW-1:0] cmp_addr,
    output logic             hit,
    output logic [DataW-1:0] rd_data
);

    logic             pf_valid;
    logic [AddrW-1:0] pf_addr;
    logic [DataW-1:0] pf_data;

    // Buffer contents; a fill overrides everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            pf_valid <= 1'b0;
            pf_addr  <= '0;
            pf_data  <= '0;
        end else if (fill) begin
            pf_valid <= 1'b1;
            pf_addr  <= fill_addr;
            pf_data  <= fill_data;
        end else if (inv) begin
            pf_valid <= 1'b0;
        end else if (upd && pf_valid && (pf_addr == upd_addr)) begin
            pf_data <= upd_data;
        end
    end

    assign hit     = pf_valid && (pf_addr == cmp_addr);
    assign rd_data = pf_data;

endmodule

// File: rtl/spi_sram_prefetch.sv
// CPU-side front end for an SPI SRAM master: single-byte reads and writes,
// with an optional one-byte prefetch of the next address after each read miss.
module spi_sram_prefetch
    import spi_sram_pkg::*;
#(
    parameter int unsigned PREFETCH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [AddrW-1:0] cpu_addr,
    input  logic [DataW-1:0] cpu_wdata,
    output logic             cpu_ack,
    output logic [DataW-1:0] cpu_rdata,
    output logic [AddrW-1:0] mem_addr,
    output logic [DataW-1:0] mem_wdata,
    output logic             mem_en,
    output logic             mem_wr,
    output logic             mem_rburst,
    output logic             mem_wburst,
    input  logic             mem_rdy,
    input  logic [DataW-1:0] mem_rdata0,
    input  logic             mem_rdata_load
);

    localparam logic PfOn = (PREFETCH != 0);

    state_t           state_q, state_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [DataW-1:0] wdata_q, wdata_d;
    logic             ack_q, ack_d;
    logic [DataW-1:0] rdata_q, rdata_d;

    logic [AddrW-1:0] addr_inc;
    logic             take;
    logic             buf_inv, buf_fill, buf_upd;
    logic             buf_hit;
    logic [DataW-1:0] buf_data;

    assign addr_inc = addr_next(addr_q);
    // A request still high during its own ack cycle must not be accepted twice.
    assign take     = cpu_req && !ack_q;

    spi_sram_pfbuf u_pfbuf (
        .clk       (clk),
        .rst       (rst),
        .inv       (buf_inv),
        .fill      (buf_fill),
        .fill_addr (addr_inc),
        .fill_data (mem_rdata0),
        .upd       (buf_upd),
        .upd_addr  (addr_q),
        .upd_data  (wdata_q),
        .cmp_addr  (cpu_addr),
        .hit       (buf_hit),
        .rd_data   (buf_data)
    );

    // Next-state, acknowledge and buffer control.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
        buf_inv  = 1'b0;
        buf_fill = 1'b0;
        buf_upd  = 1'b0;
        case (state_q)
            StIdle: begin
                if (take) begin
                    if (cpu_we) begin
                        state_d = StWrIssue;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end else if (buf_hit) begin
                        ack_d   = 1'b1;
                        rdata_d = buf_data;
                    end else begin
                        state_d = StRdIssue;
                        addr_d  = cpu_addr;
                        buf_inv = 1'b1;
                    end
                end
            end
            StRdIssue: begin
                if (mem_rdy) state_d = StRdData;
            end
            StRdData: begin
                if (mem_rdata_load) begin
                    rdata_d = mem_rdata0;
                    ack_d   = 1'b1;
                    state_d = PfOn ? StPfIssue : StIdle;
                end
            end
            StPfIssue: begin
                if (mem_rdy) state_d = StPfData;
            end
            StPfData: begin
                if (mem_rdata_load) begin
                    buf_fill = 1'b1;
                    state_d  = StIdle;
                end
            end
            StWrIssue: begin
                if (mem_rdy) begin
                    ack_d   = 1'b1;
                    buf_upd = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Master request, decoded from state; address and data come from latched
    // copies so they hold steady while the master stalls.
    always_comb begin
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_rburst = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            StRdIssue: begin
                mem_en     = 1'b1;
                mem_rburst = PfOn;
                mem_addr   = addr_q;
            end
            StRdData: begin
                mem_en     = PfOn;
                mem_rburst = PfOn;
                mem_addr   = addr_inc;
            end
            StPfIssue: begin
                mem_en     = 1'b1;
                mem_rburst = 1'b1;
                mem_addr   = addr_inc;
            end
            StWrIssue: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            default: ;
        endcase
    end

    // State and CPU-facing registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign cpu_ack    = ack_q;
    assign cpu_rdata  = rdata_q;
    assign mem_wburst = 1'b0;

endmodule

// File: tb/tb_spi_sram_prefetch.sv
// Bench for spi_sram_prefetch: SPI SRAM master/memory model, a byte-level
// reference of memory and prefetch buffer, directed vectors and random traffic.
module tb_spi_sram_prefetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [23:0] cpu_addr, mem_addr;
    logic [7:0]  cpu_wdata, cpu_rdata, mem_wdata, mem_rdata0;
    logic        mem_en, mem_wr, mem_rburst, mem_wburst, mem_rdy, mem_rdata_load;

    // Second instance without prefetch, driven by hand.
    logic        p0_req, p0_we, p0_ack;
    logic [23:0] p0_addr, p0_mem_addr;
    logic [7:0]  p0_wdata, p0_cpu_rdata, p0_mem_wdata, p0_rdata;
    logic        p0_mem_en, p0_mem_wr, p0_mem_rburst, p0_mem_wburst, p0_rdy, p0_load;

    spi_sram_prefetch #(.PREFETCH(1)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_rburst(mem_rburst), .mem_wburst(mem_wburst), .mem_rdy(mem_rdy),
        .mem_rdata0(mem_rdata0), .mem_rdata_load(mem_rdata_load)
    );

    spi_sram_prefetch #(.PREFETCH(0)) dut0 (
        .clk(clk), .rst(rst), .cpu_req(p0_req), .cpu_we(p0_we), .cpu_addr(p0_addr),
        .cpu_wdata(p0_wdata), .cpu_ack(p0_ack), .cpu_rdata(p0_cpu_rdata),
        .mem_addr(p0_mem_addr), .mem_wdata(p0_mem_wdata), .mem_en(p0_mem_en),
        .mem_wr(p0_mem_wr), .mem_rburst(p0_mem_rburst), .mem_wburst(p0_mem_wburst),
        .mem_rdy(p0_rdy), .mem_rdata0(p0_rdata), .mem_rdata_load(p0_load)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- memory contents: SRAM model and reference ----------------
    logic [7:0] sram    [int];
    logic [7:0] ref_mem [int];

    function automatic logic [7:0] dflt(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] sram_rd(input logic [23:0] a);
        if (sram.exists(int'(a))) return sram[int'(a)];
        return dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [23:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return dflt(a);
    endfunction

    // ---------------- SPI SRAM master model (one outstanding read) ----------------
    bit          pend_v = 0;
    logic [23:0] pend_addr;
    int          pend_cnt;
    int          n_accept = 0;
    int          fix_lat = -1;
    bit          stray_en = 1;
    int          inv_err = 0;
    int          stab_err = 0;
    bit          prev_stall = 0;
    logic [23:0] ps_addr;
    logic        ps_wr;
    logic [7:0]  ps_wd;

    always @(negedge clk) begin
        if (rst) begin
            pend_v = 0; mem_rdy = 0; mem_rdata_load = 0; mem_rdata0 = 8'h00; prev_stall = 0;
        end else begin
            if (prev_stall && !(mem_en && mem_addr == ps_addr && mem_wr == ps_wr
                                && mem_wdata == ps_wd)) stab_err++;
            if ((!mem_en && mem_rburst) || mem_wburst) inv_err++;
            mem_rdata_load = 0;
            if (pend_v) begin
                mem_rdy = 0;
                if (pend_cnt == 0) begin
                    mem_rdata_load = 1;
                    mem_rdata0 = sram_rd(pend_addr);
                    pend_v = 0;
                end else begin
                    pend_cnt--;
                end
            end else begin
                mem_rdy = ($urandom_range(0, 3) != 0);
                if (mem_en && mem_rdy) begin
                    n_accept++;
                    if (mem_wr) begin
                        sram[int'(mem_addr)] = mem_wdata;
                    end else begin
                        if (!mem_rburst) inv_err++;
                        pend_v = 1;
                        pend_addr = mem_addr;
                        pend_cnt = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 2));
                    end
                end
                // Stray strobes land only outside the data phases and must be ignored.
                if (stray_en && $urandom_range(0, 5) == 0) begin
                    mem_rdata_load = 1;
                    mem_rdata0 = 8'hEE;
                end
            end
            prev_stall = mem_en && !mem_rdy;
            ps_addr = mem_addr; ps_wr = mem_wr; ps_wd = mem_wdata;
        end
    end

    int p0_rb_err = 0;
    always @(negedge clk) if (p0_mem_rburst || p0_mem_wburst) p0_rb_err++;

    // ---------------- reference model of the prefetch buffer ----------------
    bit          rf_valid = 0;
    logic [23:0] rf_addr = '0;

    task automatic ref_step(input logic we, input logic [23:0] addr, input logic [7:0] wd,
                            output logic [7:0] exp_rd, output int exp_acc, output bit exp_hit);
        exp_rd = '0;
        exp_hit = 0;
        if (we) begin
            ref_mem[int'(addr)] = wd;
            exp_acc = 1;
        end else begin
            exp_rd = ref_rd(addr);
            exp_hit = rf_valid && (rf_addr == addr);
            exp_acc = exp_hit ? 0 : 2;
            if (!exp_hit) begin
                rf_valid = 1;
                rf_addr = 24'((int'(addr) + 1) % (1 << 24));
            end
        end
    endtask

    // ---------------- CPU transaction driver ----------------
    task automatic do_txn(input logic we, input logic [23:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output int lat, output int acc,
                          output int acks, output bit ok);
        int a0;
        int quiet;
        a0 = n_accept; ok = 0; lat = 0; rd = '0; acks = 0;
        cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); #1; lat++;
            if (cpu_ack) begin ok = 1; rd = cpu_rdata; acks = 1; end
        end
        // Hold the request through the ack cycle, as a CPU reacting to ack would.
        @(posedge clk); #1; cpu_req = 1'b0;
        quiet = 0;
        for (int i = 0; i < 100 && quiet < 2; i++) begin
            @(negedge clk); #1;
            if (cpu_ack) acks++;
            if (!mem_en && !pend_v) quiet++; else quiet = 0;
        end
        if (quiet < 2) ok = 0;
        acc = n_accept - a0;
    endtask

    task automatic run_check(input string tag, input logic we, input logic [23:0] addr,
                             input logic [7:0] wd, input logic [7:0] exp_rd,
                             input int exp_acc, input bit exp_hit);
        logic [7:0] rd;
        int lat, acc, acks;
        bit ok;
        do_txn(we, addr, wd, rd, lat, acc, acks, ok);
        check({tag, "_done"}, ok, 1);
        check({tag, "_acks"}, acks, 1);
        check({tag, "_mem_txns"}, acc, exp_acc);
        if (!we) check({tag, "_rdata"}, rd, exp_rd);
        if (!we && exp_hit) check({tag, "_hit_latency"}, lat, 1);
    endtask

    task automatic p0_read(input logic [23:0] addr, input logic [7:0] data, output bit issued,
                           output logic [7:0] rd, output bit ok, output int extra_en);
        p0_we = 0; p0_addr = addr; p0_req = 1; issued = 0; ok = 0; rd = '0;
        for (int i = 0; i < 20 && !issued; i++) begin
            @(negedge clk); #1;
            if (p0_mem_en && p0_mem_addr == addr) issued = 1;
        end
        @(negedge clk); #1;
        extra_en = int'(p0_mem_en);
        p0_load = 1; p0_rdata = data;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); #1; p0_load = 0;
            if (p0_ack) begin ok = 1; rd = p0_cpu_rdata; end
        end
        @(posedge clk); #1; p0_req = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (p0_mem_en) extra_en++;
        end
    endtask

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
        int          exp_acc;
        bit          exp_hit;
    } vec_t;

    vec_t        vecs [10];
    logic [23:0] pool [7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m_rd, rd;
        int m_acc, acc, acks, bad;
        bit m_hit, ok, found, issued;

        vecs[0] = '{1'b0, 24'h000100, 8'h00, 8'h5A, 2, 1'b0};
        vecs[1] = '{1'b0, 24'h000101, 8'h00, 8'hA5, 0, 1'b1};
        vecs[2] = '{1'b1, 24'h000101, 8'h3C, 8'h00, 1, 1'b0};
        vecs[3] = '{1'b0, 24'h000101, 8'h00, 8'h3C, 0, 1'b1};
        vecs[4] = '{1'b0, 24'hFFFFFF, 8'h00, 8'h11, 2, 1'b0};
        vecs[5] = '{1'b0, 24'h000000, 8'h00, 8'h22, 0, 1'b1};
        vecs[6] = '{1'b1, 24'h000050, 8'h99, 8'h00, 1, 1'b0};
        vecs[7] = '{1'b0, 24'h000000, 8'h00, 8'h22, 0, 1'b1};
        vecs[8] = '{1'b0, 24'h000050, 8'h00, 8'h99, 2, 1'b0};
        vecs[9] = '{1'b0, 24'h000051, 8'h00, 8'h44, 0, 1'b1};
        pool = '{24'h000100, 24'h000101, 24'h000102, 24'hFFFFFE, 24'hFFFFFF,
                 24'h000000, 24'h000001};

        sram[32'h100] = 8'h5A; sram[32'h101] = 8'hA5; sram[32'hFFFFFF] = 8'h11;
        sram[32'h0]   = 8'h22; sram[32'h51]  = 8'h44;
        ref_mem = sram;

        rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_rdy = 1; p0_load = 0;
        p0_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {cpu_ack, cpu_rdata, mem_en, mem_wr, mem_rburst, mem_wburst,
                                mem_addr, mem_wdata}, 64'h0);
        check("reset_pf_valid", dut.u_pfbuf.pf_valid, 0);
        rst = 0;
        @(negedge clk); #1;

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            ref_step(vecs[i].we, vecs[i].addr, vecs[i].wdata, m_rd, m_acc, m_hit);
            run_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].exp_rd, vecs[i].exp_acc, vecs[i].exp_hit);
            if (i == 0) begin
                check("vec0_pf_addr", dut.u_pfbuf.pf_addr, 24'h000101);
                check("vec0_pf_data", dut.u_pfbuf.pf_data, 8'hA5);
            end
            if (i == 4) check("vec4_pf_addr_wrap", dut.u_pfbuf.pf_addr, 24'h000000);
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic        r_we;
            logic [23:0] r_addr;
            logic [7:0]  r_wd;
            r_we = ($urandom_range(0, 3) == 0);
            r_addr = pool[$urandom_range(0, 6)];
            r_wd = 8'($urandom);
            ref_step(r_we, r_addr, r_wd, m_rd, m_acc, m_hit);
            run_check($sformatf("rnd%0d", i), r_we, r_addr, r_wd, m_rd, m_acc, m_hit);
        end

        // Request arriving while the prefetch is still in its data phase.
        fix_lat = 2; stray_en = 0;
        ref_step(1'b0, 24'h000120, 8'h00, m_rd, m_acc, m_hit);
        cpu_we = 0; cpu_addr = 24'h000120; cpu_req = 1; ok = 0; rd = '0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); #1;
            if (cpu_ack) begin ok = 1; rd = cpu_rdata; end
        end
        check("pfwait_first_rdata", rd, m_rd);
        @(posedge clk); #1; cpu_req = 0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk); #1;
            if (pend_v && !mem_en) found = 1;
        end
        check("pfwait_reach_pf_data", found, 1);
        ref_step(1'b0, 24'h000200, 8'h00, m_rd, m_acc, m_hit);
        m_acc = n_accept;
        cpu_addr = 24'h000200; cpu_req = 1; bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (mem_en) bad++;
            if (!pend_v) break;
        end
        check("pfwait_no_mem_en", bad, 0);
        ok = 0; acks = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); #1;
            if (cpu_ack) begin ok = 1; acks++; rd = cpu_rdata; end
        end
        @(posedge clk); #1; cpu_req = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (cpu_ack) acks++;
        end
        check("pfwait_acks", acks, 1);
        check("pfwait_rdata", rd, m_rd);
        check("pfwait_mem_txns", n_accept - m_acc, 2);
        fix_lat = -1; stray_en = 1;

        // Reset in the middle of a read data phase.
        cpu_we = 0; cpu_addr = 24'h000400; cpu_req = 1; found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk); #1;
            if (mem_en && mem_addr == 24'h000401 && pend_v) found = 1;
        end
        check("rst_reach_rd_data", found, 1);
        rst = 1; cpu_req = 0;
        @(negedge clk); #1;
        check("rst_outputs", {cpu_ack, cpu_rdata, mem_en, mem_wr, mem_rburst, mem_wburst,
                              mem_addr, mem_wdata}, 64'h0);
        check("rst_pf_valid", dut.u_pfbuf.pf_valid, 0);
        rst = 0; rf_valid = 0; bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (cpu_ack || mem_en) bad++;
        end
        check("rst_no_ack", bad, 0);
        ref_step(1'b0, 24'h000101, 8'h00, m_rd, m_acc, m_hit);
        run_check("post_rst_read", 1'b0, 24'h000101, 8'h00, m_rd, m_acc, m_hit);

        // Instance without prefetch.
        p0_read(24'h000300, 8'h77, issued, rd, ok, bad);
        check("nopf_issue", issued, 1);
        check("nopf_ack", ok, 1);
        check("nopf_rdata", rd, 8'h77);
        check("nopf_no_extra_mem_en", bad, 0);
        p0_read(24'h000301, 8'h88, issued, rd, ok, bad);
        check("nopf_next_is_miss", issued, 1);
        check("nopf_rdata2", rd, 8'h88);

        check("mem_rburst_rules", inv_err, 0);
        check("mem_stable_while_stalled", stab_err, 0);
        check("nopf_rburst_never", p0_rb_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
